// File: rtl/gray_rx_decoder.sv
// Two-stage Gray-code receiver: decodes sampled Gray counts, checks step legality and tracks lock.
// Define GRAY_RX_BIDIR_EN to also accept -1 steps as legal advancing steps.
module gray_rx_decoder #(
    parameter int WIDTH      = 4,
    parameter int LOCK_COUNT = 2,
    parameter int ERR_LIMIT  = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid_in,
    input  logic [WIDTH-1:0] gray_in,
    input  logic             err_clr,
    output logic [WIDTH-1:0] bin_out,
    output logic             bin_valid,
    output logic             step_err,
    output logic             locked,
    output logic [7:0]       err_cnt
);

    localparam logic [1:0] ACQUIRE = 2'd0;
    localparam logic [1:0] TRACK   = 2'd1;
    localparam logic [1:0] LOCKED  = 2'd2;

    localparam logic [3:0]       LOCK_N  = 4'(LOCK_COUNT);
    localparam logic [3:0]       ERR_N   = 4'(ERR_LIMIT);
    localparam logic [WIDTH-1:0] STEP_UP = WIDTH'(1);
`ifdef GRAY_RX_BIDIR_EN
    localparam logic [WIDTH-1:0] STEP_DN = '1;
`endif

    logic             r_s1_valid;
    logic [WIDTH-1:0] r_s1_gray;
    logic [WIDTH-1:0] r_prev;
    logic [1:0]       r_state;
    logic [3:0]       r_good;
    logic [3:0]       r_consec;

    logic [WIDTH-1:0] w_bin;
    logic [WIDTH-1:0] w_delta;
    logic             w_up;
    logic             w_legal;
    logic             w_step_err;
    logic [1:0]       w_state_next;
    logic [3:0]       w_good_next;
    logic [3:0]       w_consec_next;
    logic [7:0]       w_err_cnt_next;

    // Each binary bit is the XOR of all Gray bits at and above it.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_decode
            assign w_bin[gi] = ^r_s1_gray[WIDTH-1:gi];
        end
    endgenerate

    assign w_delta = w_bin - r_prev;
`ifdef GRAY_RX_BIDIR_EN
    assign w_up = (w_delta == STEP_UP) || (w_delta == STEP_DN);
`else
    assign w_up = (w_delta == STEP_UP);
`endif
    assign w_legal = w_up || (w_delta == '0);

    always_comb begin
        w_state_next  = r_state;
        w_good_next   = r_good;
        w_consec_next = r_consec;
        w_step_err    = 1'b0;
        if (r_s1_valid) begin
            case (r_state)
                ACQUIRE: begin
                    w_state_next  = TRACK;
                    w_good_next   = 4'd0;
                    w_consec_next = 4'd0;
                end
                TRACK: begin
                    if (!w_legal) begin
                        w_step_err  = 1'b1;
                        w_good_next = 4'd0;
                    end else if (w_up) begin
                        if (r_good + 4'd1 == LOCK_N) begin
                            w_state_next  = LOCKED;
                            w_good_next   = 4'd0;
                            w_consec_next = 4'd0;
                        end else begin
                            w_good_next = r_good + 4'd1;
                        end
                    end
                end
                LOCKED: begin
                    if (!w_legal) begin
                        w_step_err = 1'b1;
                        if (r_consec + 4'd1 == ERR_N) begin
                            w_state_next  = TRACK;
                            w_good_next   = 4'd0;
                            w_consec_next = 4'd0;
                        end else begin
                            w_consec_next = r_consec + 4'd1;
                        end
                    end else begin
                        w_consec_next = 4'd0;
                    end
                end
                default: begin
                    w_state_next = ACQUIRE;
                end
            endcase
        end
    end

    // A clear that coincides with a new error leaves exactly that one error counted.
    always_comb begin
        w_err_cnt_next = err_cnt;
        if (err_clr) begin
            w_err_cnt_next = {7'd0, w_step_err};
        end else if (w_step_err && (err_cnt != 8'hFF)) begin
            w_err_cnt_next = err_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_s1_valid <= 1'b0;
            r_s1_gray  <= '0;
            r_prev     <= '0;
            r_state    <= ACQUIRE;
            r_good     <= 4'd0;
            r_consec   <= 4'd0;
            bin_out    <= '0;
            bin_valid  <= 1'b0;
            step_err   <= 1'b0;
            err_cnt    <= 8'd0;
        end else begin
            r_s1_valid <= valid_in;
            r_s1_gray  <= gray_in;
            bin_valid  <= r_s1_valid;
            step_err   <= w_step_err;
            r_state    <= w_state_next;
            r_good     <= w_good_next;
            r_consec   <= w_consec_next;
            err_cnt    <= w_err_cnt_next;
            if (r_s1_valid) begin
                bin_out <= w_bin;
                r_prev  <= w_bin;
            end
        end
    end

    assign locked = (r_state == LOCKED);

endmodule

// File: tb/tb_gray_rx_decoder.sv
// Self-checking bench for gray_rx_decoder: directed vector table, reset corner case, randomized model check.
module tb_gray_rx_decoder;

    localparam int W = 4;
    localparam int N = 21;
`ifdef GRAY_RX_BIDIR_EN
    localparam bit BIDIR = 1'b1;
`else
    localparam bit BIDIR = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       clk_en = 1'b1;
    logic       reset = 1'b0;
    logic       valid_in = 1'b0;
    logic       err_clr = 1'b0;
    logic [3:0] gray_in = 4'd0;
    logic [3:0] bin_out;
    logic       bin_valid;
    logic       step_err;
    logic       locked;
    logic [7:0] err_cnt;

    int total = 0;
    int bad = 0;

    gray_rx_decoder dut (
        .clk(clk), .reset(reset), .valid_in(valid_in), .gray_in(gray_in), .err_clr(err_clr),
        .bin_out(bin_out), .bin_valid(bin_valid), .step_err(step_err), .locked(locked), .err_cnt(err_cnt)
    );

    always #5 if (clk_en) clk = ~clk;

    typedef struct {
        logic       v;
        logic [3:0] g;
        logic       clr;
        logic [3:0] e_bin;
        logic       e_bv;
        logic       e_se;
        logic       e_lk;
        logic [7:0] e_ec;
    } vec_t;
    vec_t tbl[N];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int e_bin, input bit e_bv, input bit e_se,
                           input bit e_lk, input int e_ec);
        chk({tag, ".bin_out"}, 32'(bin_out), 32'(e_bin));
        chk({tag, ".bin_valid"}, 32'(bin_valid), 32'(e_bv));
        chk({tag, ".step_err"}, 32'(step_err), 32'(e_se));
        chk({tag, ".locked"}, 32'(locked), 32'(e_lk));
        chk({tag, ".err_cnt"}, 32'(err_cnt), 32'(e_ec));
    endtask

    task automatic do_step(input logic v, input logic [3:0] g, input logic c);
        valid_in = v;
        gray_in  = g;
        err_clr  = c;
        @(posedge clk);
        #1;
    endtask

    function automatic int gray2bin(input int g);
        int b = 0;
        for (int k = 0; k < W; k++) b = b ^ (g >> k);
        return b & ((1 << W) - 1);
    endfunction

    function automatic logic [3:0] bin2gray(input int b);
        return 4'(b ^ (b >> 1));
    endfunction

    // Reference model: mode 0 = acquire, 1 = track, 2 = locked
    int m_mode, m_good, m_consec, m_prev, m_bin, m_ec;
    bit m_se;

    task automatic model_reset();
        m_mode = 0; m_good = 0; m_consec = 0; m_prev = 0; m_bin = 0; m_ec = 0; m_se = 0;
    endtask

    task automatic model_sample(input int b);
        int  delta;
        bit  up, legal;
        m_se = 0;
        if (m_mode == 0) begin
            m_mode = 1;
            m_good = 0;
        end else begin
            delta = (b - m_prev + (1 << W)) % (1 << W);
            up    = (delta == 1) || (BIDIR && delta == (1 << W) - 1);
            legal = up || (delta == 0);
            m_se  = !legal;
            if (m_mode == 1) begin
                if (!legal) m_good = 0;
                else if (up) m_good = m_good + 1;
                if (m_good == 2) begin
                    m_mode = 2;
                    m_consec = 0;
                end
            end else begin
                m_consec = legal ? 0 : m_consec + 1;
                if (m_consec == 3) begin
                    m_mode = 1; m_good = 0; m_consec = 0;
                end
            end
        end
        m_prev = b;
        m_bin  = b;
    endtask

    initial begin
        bit         pv;
        logic [3:0] pg;
        int         last_b, b, d, kind;
        logic       v, c;
        logic [3:0] g;

        tbl[0]  = '{1'b1, 4'h0, 1'b0, 4'd0,  1'b1, 1'b0, 1'b0, 8'd0};
        tbl[1]  = '{1'b1, 4'h1, 1'b0, 4'd1,  1'b1, 1'b0, 1'b0, 8'd0};
        tbl[2]  = '{1'b1, 4'h3, 1'b0, 4'd2,  1'b1, 1'b0, 1'b1, 8'd0};
        tbl[3]  = '{1'b1, 4'h2, 1'b0, 4'd3,  1'b1, 1'b0, 1'b1, 8'd0};
        tbl[4]  = '{1'b1, 4'h9, 1'b0, 4'd14, 1'b1, 1'b1, 1'b1, 8'd1};
        tbl[5]  = '{1'b1, 4'h8, 1'b0, 4'd15, 1'b1, 1'b0, 1'b1, 8'd1};
        tbl[6]  = '{1'b1, 4'h0, 1'b0, 4'd0,  1'b1, 1'b0, 1'b1, 8'd1};
        tbl[7]  = '{1'b1, 4'h1, 1'b0, 4'd1,  1'b1, 1'b0, 1'b1, 8'd1};
        tbl[8]  = '{1'b1, 4'h3, 1'b0, 4'd2,  1'b1, 1'b0, 1'b1, 8'd1};
        tbl[9]  = '{1'b1, 4'h7, 1'b0, 4'd5,  1'b1, 1'b1, 1'b1, 8'd2};
        tbl[10] = '{1'b1, 4'h7, 1'b0, 4'd5,  1'b1, 1'b0, 1'b1, 8'd2};
        tbl[11] = '{1'b1, 4'hD, 1'b0, 4'd9,  1'b1, 1'b1, 1'b1, 8'd3};
        tbl[12] = '{1'b1, 4'h0, 1'b0, 4'd0,  1'b1, 1'b1, 1'b1, 8'd4};
        tbl[13] = '{1'b1, 4'hA, 1'b0, 4'd12, 1'b1, 1'b1, 1'b0, 8'd5};
        tbl[14] = '{1'b0, 4'h0, 1'b0, 4'd12, 1'b0, 1'b0, 1'b0, 8'd5};
        tbl[15] = '{1'b0, 4'h0, 1'b1, 4'd12, 1'b0, 1'b0, 1'b0, 8'd0};
        tbl[16] = '{1'b1, 4'hB, 1'b0, 4'd13, 1'b1, 1'b0, 1'b0, 8'd0};
        tbl[17] = '{1'b1, 4'h4, 1'b1, 4'd7,  1'b1, 1'b1, 1'b0, 8'd1};
        tbl[18] = '{1'b1, 4'h7, 1'b0, 4'd5,  1'b1, 1'b1, 1'b0, 8'd2};
        tbl[19] = '{1'b1, 4'h6, 1'b0, 4'd4,  1'b1, !BIDIR, 1'b0, BIDIR ? 8'd2 : 8'd3};
        tbl[20] = '{1'b0, 4'h0, 1'b0, 4'd4,  1'b0, 1'b0, 1'b0, BIDIR ? 8'd2 : 8'd3};

        // Reset state
        #2;
        chk_all("reset", 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Directed vectors; err_clr of entry k is driven on the edge its sample reaches the outputs
        for (int j = 0; j <= N; j++) begin
            if (j < N) do_step(tbl[j].v, tbl[j].g, (j > 0) ? tbl[j-1].clr : 1'b0);
            else       do_step(1'b0, 4'h0, tbl[j-1].clr);
            if (j > 0) begin
                chk_all($sformatf("vec%0d", j - 1), int'(tbl[j-1].e_bin), tbl[j-1].e_bv,
                        tbl[j-1].e_se, tbl[j-1].e_lk, int'(tbl[j-1].e_ec));
                $display("vec %0d: gray=%0h bin_out=%0d valid=%0b step_err=%0b locked=%0b err_cnt=%0d",
                         j - 1, tbl[j-1].g, bin_out, bin_valid, step_err, locked, err_cnt);
            end
        end

        // Relock, leave a sample in flight, then reset with the clock stopped
        do_step(1'b1, 4'h0, 1'b0);
        do_step(1'b1, 4'h1, 1'b0);
        do_step(1'b1, 4'h3, 1'b0);
        do_step(1'b1, 4'h2, 1'b0);
        chk("relock.locked", 32'(locked), 32'd1);
        clk_en = 1'b0;
        #3;
        reset = 1'b0;
        #1;
        chk_all("async_reset", 0, 0, 0, 0, 0);
        $display("async reset: bin_out=%0d valid=%0b locked=%0b err_cnt=%0d", bin_out, bin_valid, locked, err_cnt);
        #3;
        reset = 1'b1;
        #2;
        clk_en = 1'b1;
        do_step(1'b0, 4'h0, 1'b0);
        chk("flush.bin_valid", 32'(bin_valid), 32'd0);
        do_step(1'b1, bin2gray(6), 1'b0);
        do_step(1'b1, bin2gray(7), 1'b0);
        chk_all("post_reset_first", 6, 1, 0, 0, 0);
        do_step(1'b0, 4'h0, 1'b0);
        chk_all("post_reset_second", 7, 1, 0, 0, 0);

        // Randomized run against the reference model, starting with a saturation burst
        reset = 1'b0;
        #3;
        reset = 1'b1;
        model_reset();
        pv = 1'b0;
        pg = 4'h0;
        last_b = 0;
        for (int j = 0; j < 700; j++) begin
            if (j < 270) begin
                v = 1'b1;
                b = (j % 2 == 1) ? 8 : 0;
                c = 1'b0;
            end else begin
                v    = ($urandom_range(0, 3) != 0);
                kind = $urandom_range(0, 5);
                case (kind)
                    0:       d = 0;
                    1, 2:    d = 1;
                    3:       d = 15;
                    default: d = $urandom_range(0, 15);
                endcase
                b = (last_b + d) % 16;
                c = ($urandom_range(0, 19) == 0);
            end
            g = bin2gray(b);
            if (v) last_b = b;
            do_step(v, g, c);
            m_se = 0;
            if (pv) model_sample(gray2bin(int'(pg)));
            if (c) m_ec = m_se ? 1 : 0;
            else if (m_se && m_ec < 255) m_ec = m_ec + 1;
            chk_all($sformatf("rnd%0d", j), m_bin, pv, m_se, m_mode == 2, m_ec);
            $display("rnd %0d: gray=%0h clr=%0b bin_out=%0d valid=%0b step_err=%0b locked=%0b err_cnt=%0d",
                     j, g, c, bin_out, bin_valid, step_err, locked, err_cnt);
            pv = v;
            pg = g;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
